// File: rtl/timer_cmp_if.sv
// ---------------------------------------------------------------------------
// timer_cmp_if
//   Register-access bundle between the core's 32-bit CSR/MMIO path and the
//   timer comparator.
//
//   Handshake: a request is a cycle with req_i=1 at a rising clk edge. Every
//   request is accepted, so there is no ready signal. The response is a
//   single-cycle rvalid_o pulse in the cycle right after that edge, with
//   rdata_o and err_o valid only while rvalid_o=1. Responses come back in
//   request order, and back-to-back requests are allowed.
//
//   Signals:
//     req_i     master -> slave  access request
//     we_i      master -> slave  1 = write, 0 = read
//     addr_i    master -> slave  word index (0..4 decoded, 5..7 error)
//     wdata_i   master -> slave  write data
//     rvalid_o  slave -> master  response strobe
//     rdata_o   slave -> master  read data, 0 for writes and errors
//     err_o     slave -> master  error flag, qualified by rvalid_o
// ---------------------------------------------------------------------------
interface timer_cmp_if;
    logic        req_i;
    logic        we_i;
    logic [2:0]  addr_i;
    logic [31:0] wdata_i;
    logic        rvalid_o;
    logic [31:0] rdata_o;
    logic        err_o;

    modport master (
        output req_i,
        output we_i,
        output addr_i,
        output wdata_i,
        input  rvalid_o,
        input  rdata_o,
        input  err_o
    );

    modport slave (
        input  req_i,
        input  we_i,
        input  addr_i,
        input  wdata_i,
        output rvalid_o,
        output rdata_o,
        output err_o
    );
endinterface

// File: rtl/timer_cmp.sv
// ---------------------------------------------------------------------------
// timer_cmp
//   Bus-side reader and comparator for the free-running timer.
//   - A TIME_LO read latches the upper half of the count into snap_hi, and a
//     following TIME_HI read returns that snapshot. The 64-bit value read as
//     LO then HI therefore cannot tear across a carry.
//   - The compare value is staged: CMP_LO only fills a holding register, and
//     CMP_HI commits the full value in one edge. As a result, the comparator
//     never sees a half-updated compare.
//   - irq_o is the registered result of en && (timer >= cmp).
//
//   Ports:
//     clk          clock
//     rst          synchronous reset, active-high
//     timer_val_i  current timer count (CSR_XLEN bits), sampled every clk
//     bus          register access port (timer_cmp_if.slave)
//     irq_o        machine timer interrupt, level
//
//   Register map (word index):
//     0 TIME_LO  R   timer[31:0]; latches snap_hi
//     1 TIME_HI  R   snap_hi, zero-extended
//     2 CMP_LO   RW  read: live cmp[31:0]; write: staging register only
//     3 CMP_HI   RW  read: live cmp upper bits; write: commits {wdata, stage}
//     4 CTRL     RW  bit0 en (RW), bit1 pend (read, write-1-to-clear)
//   The following accesses return err_o=1 and rdata_o=0:
//     - a write to TIME_LO or TIME_HI
//     - any access to word index 5..7
// ---------------------------------------------------------------------------
module timer_cmp #(
    parameter int CSR_XLEN = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CSR_XLEN-1:0] timer_val_i,
    timer_cmp_if.slave          bus,
    output logic                irq_o
);

    localparam int HI_W = CSR_XLEN - 32;

    localparam logic [2:0] ADDR_TIME_LO = 3'd0;
    localparam logic [2:0] ADDR_TIME_HI = 3'd1;
    localparam logic [2:0] ADDR_CMP_LO  = 3'd2;
    localparam logic [2:0] ADDR_CMP_HI  = 3'd3;
    localparam logic [2:0] ADDR_CTRL    = 3'd4;

    // Architectural state
    logic [HI_W-1:0]     snap_hi;
    logic [31:0]         cmp_stage_lo;
    logic [CSR_XLEN-1:0] cmp;
    logic                en;
    logic                pend;

    // Registered outputs
    logic                rvalid_q;
    logic [31:0]         rdata_q;
    logic                err_q;
    logic                irq_q;

    // Decode and datapath
    logic                addr_bad;
    logic                wr_time;
    logic                acc_err;
    logic                wr_ok;
    logic                w1c_pend;
    logic                match;
    logic [31:0]         snap_hi_ext;
    logic [31:0]         cmp_hi_ext;
    logic [31:0]         rd_data;

    always_comb begin
        // The upper words are narrower than 32 bits when CSR_XLEN < 64, so
        // they are zero-extended here.
        snap_hi_ext             = '0;
        snap_hi_ext[HI_W-1:0]   = snap_hi;
        cmp_hi_ext              = '0;
        cmp_hi_ext[HI_W-1:0]    = cmp[CSR_XLEN-1:32];

        addr_bad = (bus.addr_i > ADDR_CTRL);
        wr_time  = bus.we_i && ((bus.addr_i == ADDR_TIME_LO) || (bus.addr_i == ADDR_TIME_HI));
        acc_err  = addr_bad || wr_time;
        wr_ok    = bus.req_i && bus.we_i && !acc_err;
        w1c_pend = wr_ok && (bus.addr_i == ADDR_CTRL) && bus.wdata_i[1];

        // Unsigned, full-width compare against the committed value only.
        match = en && (timer_val_i >= cmp);

        rd_data = '0;
        if (!bus.we_i && !acc_err) begin
            case (bus.addr_i)
                ADDR_TIME_LO: rd_data = timer_val_i[31:0];
                ADDR_TIME_HI: rd_data = snap_hi_ext;
                ADDR_CMP_LO:  rd_data = cmp[31:0];
                ADDR_CMP_HI:  rd_data = cmp_hi_ext;
                ADDR_CTRL:    rd_data = {30'b0, pend, en};
                default:      rd_data = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // A request sampled in the same edge as rst is dropped here,
            // because rvalid_q is cleared rather than loaded.
            rvalid_q     <= 1'b0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            irq_q        <= 1'b0;
            snap_hi      <= '0;
            cmp_stage_lo <= '0;
            cmp          <= '1;
            en           <= 1'b0;
            pend         <= 1'b0;
        end else begin
            rvalid_q <= bus.req_i;
            err_q    <= bus.req_i && acc_err;
            rdata_q  <= bus.req_i ? rd_data : 32'd0;

            irq_q <= match;
            // In the same edge, a new match wins over a write-1-to-clear.
            pend  <= match || (pend && !w1c_pend);

            if (bus.req_i && !bus.we_i && (bus.addr_i == ADDR_TIME_LO)) begin
                snap_hi <= timer_val_i[CSR_XLEN-1:32];
            end

            if (wr_ok) begin
                case (bus.addr_i)
                    ADDR_CMP_LO: cmp_stage_lo <= bus.wdata_i;
                    ADDR_CMP_HI: cmp          <= {bus.wdata_i[HI_W-1:0], cmp_stage_lo};
                    ADDR_CTRL:   en           <= bus.wdata_i[0];
                    default:     ;
                endcase
            end
        end
    end

    assign bus.rvalid_o = rvalid_q;
    assign bus.rdata_o  = rdata_q;
    assign bus.err_o    = err_q;
    assign irq_o        = irq_q;

endmodule

// File: tb/tb_timer_cmp.sv
// ---------------------------------------------------------------------------
// tb_timer_cmp
//   Directed scenarios for the documented corner cases, followed by
//   randomized traffic. Expected values come from a register-level reference
//   model that applies the access rules once per clock edge.
// ---------------------------------------------------------------------------
module tb_timer_cmp;

    localparam int XLEN = 64;

    // ---------------- clock / reset ----------------
    logic            clk;
    logic            rst;
    logic [XLEN-1:0] timer;
    logic            irq;

    timer_cmp_if bus ();

    timer_cmp #(.CSR_XLEN(XLEN)) dut (
        .clk         (clk),
        .rst         (rst),
        .timer_val_i (timer),
        .bus         (bus.slave),
        .irq_o       (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;

    // Each entry is {err, rdata} for one outstanding response.
    logic [32:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [63:0] m_cmp;
    logic [31:0] m_stage;
    logic [31:0] m_snap;
    logic        m_en;
    logic        m_pend;
    logic        m_irq;
    logic        m_rvalid;

    task automatic model_edge(input logic r, input logic req, input logic we,
                              input logic [2:0] a, input logic [31:0] wd,
                              input logic [63:0] t);
        logic        hit;
        logic        clr;
        logic        bad;
        logic [31:0] data;
        if (r) begin
            m_cmp    = '1;
            m_stage  = '0;
            m_snap   = '0;
            m_en     = 1'b0;
            m_pend   = 1'b0;
            m_irq    = 1'b0;
            m_rvalid = 1'b0;
            exp_q.delete();
            return;
        end
        hit  = m_en && (t >= m_cmp);
        bad  = (a > 3'd4) || (we && a < 3'd2);
        clr  = req && we && !bad && (a == 3'd4) && wd[1];
        data = '0;
        m_rvalid = req;
        if (req) begin
            if (!we && !bad) begin
                case (a)
                    3'd0:    data = t[31:0];
                    3'd1:    data = m_snap;
                    3'd2:    data = m_cmp[31:0];
                    3'd3:    data = m_cmp[63:32];
                    default: data = {30'b0, m_pend, m_en};
                endcase
            end
            exp_q.push_back({bad, data});
            if (!we && a == 3'd0) m_snap = t[63:32];
            if (we && !bad) begin
                if (a == 3'd2) m_stage = wd;
                if (a == 3'd3) m_cmp = {wd, m_stage};
                if (a == 3'd4) m_en = wd[0];
            end
        end
        if (hit)      m_pend = 1'b1;
        else if (clr) m_pend = 1'b0;
        m_irq = hit;
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick(input logic r, input logic req, input logic we,
                        input logic [2:0] a, input logic [31:0] wd);
        logic [32:0] e;
        rst         = r;
        bus.req_i   = req;
        bus.we_i    = we;
        bus.addr_i  = a;
        bus.wdata_i = wd;
        @(posedge clk);
        model_edge(r, req, we, a, wd, timer);
        #1;
        check("rvalid", {63'b0, bus.rvalid_o}, {63'b0, m_rvalid});
        if (m_rvalid) begin
            e = exp_q.pop_front();
            check("rdata", {32'b0, bus.rdata_o}, {32'b0, e[31:0]});
            check("err", {63'b0, bus.err_o}, {63'b0, e[32]});
        end
        if (r) begin
            check("rst_rdata", {32'b0, bus.rdata_o}, 64'd0);
            check("rst_err", {63'b0, bus.err_o}, 64'd0);
        end
        check("irq", {63'b0, irq}, {63'b0, m_irq});
    endtask

    task automatic idle();
        tick(1'b0, 1'b0, 1'b0, 3'd0, 32'd0);
    endtask

    task automatic rd(input logic [2:0] a);
        tick(1'b0, 1'b1, 1'b0, a, 32'd0);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        tick(1'b0, 1'b1, 1'b1, a, d);
    endtask

    task automatic do_reset();
        tick(1'b1, 1'b0, 1'b0, 3'd0, 32'd0);
        tick(1'b1, 1'b0, 1'b0, 3'd0, 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst         = 1'b1;
        timer       = '0;
        bus.req_i   = 1'b0;
        bus.we_i    = 1'b0;
        bus.addr_i  = '0;
        bus.wdata_i = '0;

        do_reset();
        check("rst_irq", {63'b0, irq}, 64'd0);
        check("rst_rvalid", {63'b0, bus.rvalid_o}, 64'd0);
        rd(3'd4); check("ctrl_rst", {32'b0, bus.rdata_o}, 64'h0);
        rd(3'd3); check("cmphi_rst", {32'b0, bus.rdata_o}, 64'hFFFF_FFFF);

        // Snapshot read across a carry into the upper word.
        timer = 64'h0000_0001_FFFF_FFFF;
        rd(3'd0); check("time_lo", {32'b0, bus.rdata_o}, 64'hFFFF_FFFF);
        timer = 64'h0000_0002_0000_0000;
        rd(3'd1); check("time_hi_snap", {32'b0, bus.rdata_o}, 64'h1);

        // Staging CMP_LO must not disturb the live compare.
        timer = 64'h3;
        wr(3'd2, 32'h5);
        wr(3'd3, 32'h0);
        wr(3'd4, 32'h1);
        idle(); check("irq_below5", {63'b0, irq}, 64'd0);
        wr(3'd2, 32'h10); check("irq_stage", {63'b0, irq}, 64'd0);
        rd(3'd2); check("cmp_live", {32'b0, bus.rdata_o}, 64'h5);
        wr(3'd3, 32'h0);
        timer = 64'hF;
        idle(); check("irq_f", {63'b0, irq}, 64'd0);
        timer = 64'h10;
        idle(); check("irq_cross", {63'b0, irq}, 64'd1);

        // Set beats clear; later clear after en dropped.
        wr(3'd4, 32'h3);
        rd(3'd4); check("pend_kept", {32'b0, bus.rdata_o}, 64'h3);
        wr(3'd4, 32'h0);
        wr(3'd4, 32'h2); check("irq_off", {63'b0, irq}, 64'd0);
        rd(3'd4); check("pend_clr", {32'b0, bus.rdata_o}, 64'h0);

        // Error accesses.
        wr(3'd1, 32'hDEAD_BEEF);
        check("err_wr_time", {63'b0, bus.err_o}, 64'd1);
        rd(3'd5);
        check("err_addr5", {63'b0, bus.err_o}, 64'd1);
        check("rdata_addr5", {32'b0, bus.rdata_o}, 64'd0);
        rd(3'd2); check("cmp_after_err", {32'b0, bus.rdata_o}, 64'h10);

        // Reset in the same edge as a request drops its response.
        tick(1'b1, 1'b1, 1'b0, 3'd4, 32'd0);
        check("rst_drop", {63'b0, bus.rvalid_o}, 64'd0);
        rd(3'd3); check("cmphi_rst2", {32'b0, bus.rdata_o}, 64'hFFFF_FFFF);
        rd(3'd2); check("cmplo_rst2", {32'b0, bus.rdata_o}, 64'hFFFF_FFFF);
        rd(3'd1); check("snap_rst2", {32'b0, bus.rdata_o}, 64'h0);

        // cmp = all ones only fires at all ones; wrap drops irq, pend stays.
        wr(3'd4, 32'h1);
        timer = '1 - 64'd1;
        idle(); check("irq_allones_m1", {63'b0, irq}, 64'd0);
        timer = '1;
        idle(); check("irq_allones", {63'b0, irq}, 64'd1);
        timer = '0;
        idle(); check("irq_wrap", {63'b0, irq}, 64'd0);
        rd(3'd4); check("pend_wrap", {32'b0, bus.rdata_o}, 64'h3);

        // cmp = 0 fires on the cycle after commit.
        wr(3'd2, 32'h0);
        wr(3'd3, 32'h0);
        idle(); check("irq_cmp0", {63'b0, irq}, 64'd1);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            int          mode;
            int          op;
            logic [2:0]  a;
            logic [31:0] d;
            if ($urandom_range(0, 249) == 0) begin
                tick(1'b1, $urandom_range(0, 1) == 1, 1'b0, 3'($urandom_range(0, 7)), 32'd0);
                continue;
            end
            mode = $urandom_range(0, 9);
            case (mode)
                0:       timer = m_cmp - 64'($urandom_range(0, 3));
                1:       timer = '1 - 64'($urandom_range(0, 2));
                2:       timer = {$urandom, $urandom};
                default: timer = timer + 64'($urandom_range(0, 3));
            endcase
            a = 3'($urandom_range(0, 7));
            d = ($urandom_range(0, 2) == 0) ? $urandom : 32'(timer[31:0] + $urandom_range(0, 8));
            if (a == 3'd3 && $urandom_range(0, 1) == 1) d = timer[63:32];
            op = $urandom_range(0, 5);
            if (op < 2)      idle();
            else if (op < 4) rd(a);
            else             wr(a, d);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
